// File: rtl/db_sao_pkg.sv
// Shared definitions for the SAO band-offset statistics block.
package db_sao_pkg;

  localparam int BAND_NUM   = 32;
  localparam int BAND_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT
  } sao_state_e;

  // Band index is the top five bits of the pixel. The pixel is passed
  // zero-extended to 16 bits together with its real bit depth.
  function automatic logic [BAND_IDX_W-1:0] band_sel(input logic [15:0] pix,
                                                     input int          bit_depth);
    logic [15:0] sh;
    sh = pix >> (bit_depth - BAND_IDX_W);
    return sh[BAND_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/db_sao_bo_lane.sv
// One lane of the front end: signed original-minus-deblocked difference,
// band index of the deblocked pixel and the lane valid. Purely combinational.
module db_sao_bo_lane
  import db_sao_pkg::*;
#(
  parameter int BIT_DEPTH = 8
) (
  input  logic [BIT_DEPTH-1:0]        dp,
  input  logic [BIT_DEPTH-1:0]        op,
  input  logic                        en,
  output logic signed [BIT_DEPTH:0]   diff,
  output logic [BAND_IDX_W-1:0]       band,
  output logic                        vld
);

  // Both operands are zero-extended by one bit so the full range of op-dp fits.
  assign diff = $signed({1'b0, op}) - $signed({1'b0, dp});
  assign band = band_sel(16'(dp), BIT_DEPTH);
  assign vld  = en;

endmodule

// File: rtl/db_sao_bo_stat.sv
// SAO band-offset statistics: accumulates per-band sum of (op-dp) and pixel
// counts over a block, then streams the 32 band results one per cycle.
module db_sao_bo_stat
  import db_sao_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int LANES     = 4,
  parameter int MAX_PIX   = 4096,
  parameter int SUM_W     = BIT_DEPTH + 1 + $clog2(MAX_PIX),
  parameter int CNT_W     = $clog2(MAX_PIX) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  input  logic [LANES*BIT_DEPTH-1:0] dp_i,
  input  logic [LANES*BIT_DEPTH-1:0] op_i,
  output logic                       busy_o,
  output logic                       band_vld_o,
  output logic [BAND_IDX_W-1:0]      band_idx_o,
  output logic [SUM_W-1:0]           band_sum_o,
  output logic [CNT_W-1:0]           band_cnt_o,
  output logic                       done_o
);

  localparam int DIFF_W = BIT_DEPTH + 1;

  sao_state_e                  state_q, state_d;
  logic [BAND_IDX_W-1:0]       idx_q;
  logic                        acc_en;
  logic                        out_act;

  logic signed [DIFF_W-1:0]    diff_p0 [LANES];
  logic [BAND_IDX_W-1:0]       band_p0 [LANES];
  logic [LANES-1:0]            vld_p0;
  logic signed [DIFF_W-1:0]    diff_p1 [LANES];
  logic [BAND_IDX_W-1:0]       band_p1 [LANES];
  logic [LANES-1:0]            vld_p1;

  logic signed [SUM_W-1:0]     band_add [BAND_NUM];
  logic [CNT_W-1:0]            band_n   [BAND_NUM];
  logic signed [SUM_W-1:0]     sum_q    [BAND_NUM];
  logic [CNT_W-1:0]            cnt_q    [BAND_NUM];

  function automatic logic [CNT_W-1:0] cnt_sat(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Beats are only taken while accumulating.
  assign acc_en = (state_q == ACC) && valid_i;

  // ---- stage p0: per-lane difference and band ----
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    db_sao_bo_lane #(.BIT_DEPTH(BIT_DEPTH)) u_lane (
      .dp   (dp_i[k*BIT_DEPTH +: BIT_DEPTH]),
      .op   (op_i[k*BIT_DEPTH +: BIT_DEPTH]),
      .en   (acc_en),
      .diff (diff_p0[k]),
      .band (band_p0[k]),
      .vld  (vld_p0[k])
    );
  end

  // ---- stage p1: register lane data; only the valids are reset ----
  always_ff @(posedge clk) begin
    diff_p1 <= diff_p0;
    band_p1 <= band_p0;
  end

  // Lane valid pipeline register.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= '0;
    else     vld_p1 <= vld_p0;
  end

  // Gather every lane into its band so colliding lanes all contribute.
  always_comb begin
    for (int b = 0; b < BAND_NUM; b++) begin
      band_add[b] = '0;
      band_n[b]   = '0;
      for (int k = 0; k < LANES; k++) begin
        if (vld_p1[k] && (band_p1[k] == BAND_IDX_W'(b))) begin
          band_add[b] = band_add[b] + SUM_W'(diff_p1[k]);
          band_n[b]   = band_n[b] + CNT_W'(1);
        end
      end
    end
  end

  // ---- stage p2: band accumulators, cleared on reset or an accepted start ----
  always_ff @(posedge clk) begin
    if (rst || ((state_q == IDLE) && start_i)) begin
      for (int b = 0; b < BAND_NUM; b++) begin
        sum_q[b] <= '0;
        cnt_q[b] <= '0;
      end
    end else if (|vld_p1) begin
      for (int b = 0; b < BAND_NUM; b++) begin
        sum_q[b] <= sum_q[b] + band_add[b];
        cnt_q[b] <= cnt_sat(cnt_q[b], band_n[b]);
      end
    end
  end

  // State register and output band counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= (state_q == OUT) ? idx_q + BAND_IDX_W'(1) : '0;
    end
  end

  // Next-state logic; DRAIN gives the last beat time to reach the accumulators.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)                state_d = ACC;
      ACC:     if (valid_i && last_i)      state_d = DRAIN;
      DRAIN:                               state_d = OUT;
      OUT:     if (idx_q == 5'd31)         state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  assign out_act    = (state_q == OUT) && !rst;
  assign busy_o     = (state_q != IDLE) && !rst;
  assign band_vld_o = out_act;
  assign band_idx_o = out_act ? idx_q : '0;
  assign band_sum_o = out_act ? sum_q[idx_q] : '0;
  assign band_cnt_o = out_act ? cnt_q[idx_q] : '0;
  assign done_o     = out_act && (idx_q == 5'd31);

endmodule

// File: tb/tb_db_sao_bo_stat.sv
// Randomized bench for db_sao_bo_stat with a per-band reference model.
module tb_db_sao_bo_stat;

  localparam int SW   = 21;
  localparam int CW   = 13;
  localparam int CMAX = 8191;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, valid_i, last_i;
  logic [31:0] dp_i, op_i;
  logic        busy_o, band_vld_o, done_o;
  logic [4:0]  band_idx_o;
  logic [SW-1:0] band_sum_o;
  logic [CW-1:0] band_cnt_o;

  logic        start10, valid10, last10;
  logic [9:0]  dp10, op10;
  logic        busy10, vld10, done10;
  logic [4:0]  idx10;
  logic [22:0] sum10;
  logic [12:0] cnt10;

  int     errors = 0;
  int     checks = 0;
  longint exp_sum [32];
  longint exp_cnt [32];
  longint obs_sum [32];
  longint obs_cnt [32];

  always #5 clk = ~clk;

  db_sao_bo_stat dut (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i), .last_i(last_i),
    .dp_i(dp_i), .op_i(op_i), .busy_o(busy_o), .band_vld_o(band_vld_o),
    .band_idx_o(band_idx_o), .band_sum_o(band_sum_o), .band_cnt_o(band_cnt_o),
    .done_o(done_o)
  );

  db_sao_bo_stat #(.BIT_DEPTH(10), .LANES(1)) dut10 (
    .clk(clk), .rst(rst), .start_i(start10), .valid_i(valid10), .last_i(last10),
    .dp_i(dp10), .op_i(op10), .busy_o(busy10), .band_vld_o(vld10),
    .band_idx_o(idx10), .band_sum_o(sum10), .band_cnt_o(cnt10), .done_o(done10)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each 8-bit pixel falls in band dp/8 and contributes op-dp.
  task automatic model_beat(input logic [31:0] dp, input logic [31:0] op);
    for (int k = 0; k < 4; k++) begin
      int d, o;
      d = int'(dp[k*8 +: 8]);
      o = int'(op[k*8 +: 8]);
      exp_sum[d / 8] += longint'(o - d);
      exp_cnt[d / 8] += 1;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_vld"},  band_vld_o, 0);
    chk({tag, "_idx"},  band_idx_o, 0);
    chk({tag, "_sum"},  band_sum_o, 0);
    chk({tag, "_cnt"},  band_cnt_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // mode 0: random pixels with gaps, 1: fixed vectors, 2: two colliding bands.
  // inj drives start_i mid-block and valid_i during output; rst_at resets at that band.
  task automatic run_block(input int nbeats, input int mode, input logic [31:0] dpv,
                           input logic [31:0] opv, input bit inj, input int rst_at);
    int t;
    for (int b = 0; b < 32; b++) begin
      exp_sum[b] = 0; exp_cnt[b] = 0; obs_sum[b] = 0; obs_cnt[b] = 0;
    end
    start_i = 1; valid_i = 1; last_i = 1; dp_i = $urandom; op_i = $urandom;
    step();
    start_i = 0; valid_i = 0; last_i = 0;
    chk("busy_after_start", busy_o, 1);
    for (int i = 0; i < nbeats; i++) begin
      if (mode == 0 && $urandom_range(0, 3) == 0) begin
        valid_i = 0; last_i = $urandom; dp_i = $urandom; op_i = $urandom;
        step();
      end
      case (mode)
        1: begin dp_i = dpv; op_i = opv; end
        2: begin
          for (int k = 0; k < 4; k++)
            dp_i[k*8 +: 8] = {($urandom_range(0, 1) == 1) ? 5'd3 : 5'd20, 3'($urandom)};
          op_i = $urandom;
        end
        default: begin dp_i = $urandom; op_i = $urandom; end
      endcase
      valid_i = 1;
      last_i  = (i == nbeats - 1);
      start_i = inj && (i == nbeats / 2);
      model_beat(dp_i, op_i);
      step();
    end
    valid_i = 0; last_i = 0; start_i = 0;
    chk("drain_vld", band_vld_o, 0);
    t = 0;
    while (!band_vld_o && t < 40) begin
      step();
      t++;
    end
    chk("lat_band0", t, 1);
    if (!band_vld_o) return;
    for (int b = 0; b < 32; b++) begin
      chk($sformatf("b%0d_vld", b), band_vld_o, 1);
      chk($sformatf("b%0d_idx", b), band_idx_o, b);
      chk($sformatf("b%0d_done", b), done_o, (b == 31) ? 1 : 0);
      obs_sum[b] = longint'($signed(band_sum_o));
      obs_cnt[b] = longint'(band_cnt_o);
      chk($sformatf("b%0d_sum", b), obs_sum[b], exp_sum[b]);
      chk($sformatf("b%0d_cnt", b), obs_cnt[b], (exp_cnt[b] > CMAX) ? CMAX : exp_cnt[b]);
      if (inj) begin
        valid_i = 1; last_i = $urandom; dp_i = $urandom; op_i = $urandom;
      end
      if (b == rst_at) begin
        rst = 1; valid_i = 0; last_i = 0;
        step();
        chk_zero_outputs("rst_out");
        rst = 0;
        return;
      end
      step();
    end
    valid_i = 0; last_i = 0;
    chk("idle_vld", band_vld_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
  endtask

  // Reset in the middle of accumulation.
  task automatic abort_acc();
    start_i = 1;
    step();
    start_i = 0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; dp_i = $urandom; op_i = $urandom;
      step();
    end
    valid_i = 0; rst = 1;
    step();
    chk_zero_outputs("rst_acc");
    rst = 0;
  endtask

  task automatic run10();
    int t;
    start10 = 1;
    step();
    start10 = 0; valid10 = 1; last10 = 1; dp10 = 10'd1023; op10 = 10'd1000;
    step();
    valid10 = 0; last10 = 0;
    t = 0;
    while (!vld10 && t < 40) begin
      step();
      t++;
    end
    chk("d10_lat", t, 1);
    if (!vld10) return;
    for (int b = 0; b < 32; b++) begin
      chk($sformatf("d10_b%0d_idx", b), idx10, b);
      chk($sformatf("d10_b%0d_sum", b), longint'($signed(sum10)), (b == 31) ? -23 : 0);
      chk($sformatf("d10_b%0d_cnt", b), cnt10, (b == 31) ? 1 : 0);
      chk($sformatf("d10_b%0d_done", b), done10, (b == 31) ? 1 : 0);
      step();
    end
    chk("d10_idle_busy", busy10, 0);
  endtask

  initial begin
    rst = 1; start_i = 0; valid_i = 0; last_i = 0; dp_i = '0; op_i = '0;
    start10 = 0; valid10 = 0; last10 = 0; dp10 = '0; op10 = '0;
    step();
    step();
    chk_zero_outputs("reset");
    rst = 0;
    step();
    chk_zero_outputs("post_reset_idle");

    run_block(1, 1, {4{8'd16}}, {4{8'd20}}, 0, -1);
    chk("single_b2_sum", obs_sum[2], 16);
    chk("single_b2_cnt", obs_cnt[2], 4);

    run_block(1024, 1, {4{8'd255}}, {4{8'd0}}, 0, -1);
    chk("full_b31_sum", obs_sum[31], -1044480);
    chk("full_b31_cnt", obs_cnt[31], 4096);

    run_block(1, 1, {8'd255, 8'd8, 8'd8, 8'd0}, {8'd255, 8'd10, 8'd7, 8'd1}, 0, -1);
    chk("mixed_b0_sum", obs_sum[0], 1);
    chk("mixed_b0_cnt", obs_cnt[0], 1);
    chk("mixed_b1_sum", obs_sum[1], 1);
    chk("mixed_b1_cnt", obs_cnt[1], 2);
    chk("mixed_b31_sum", obs_sum[31], 0);
    chk("mixed_b31_cnt", obs_cnt[31], 1);

    for (int r = 0; r < 4; r++)
      run_block($urandom_range(5, 60), 0, '0, '0, 0, -1);
    run_block(40, 2, '0, '0, 0, -1);
    run_block(30, 0, '0, '0, 1, -1);
    run_block(20, 0, '0, '0, 0, 10);
    run_block(10, 0, '0, '0, 0, -1);
    abort_acc();
    run_block(15, 2, '0, '0, 0, -1);
    run_block(2100, 1, {4{8'd100}}, {4{8'd100}}, 0, -1);
    run10();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
